uart_rx_dev: RTL

- Memory-mapped UART receiver for the demo system's device bus; the receive-side counterpart of the transmit-only UART.
- Samples the asynchronous serial input and deframes 8N1 characters (8 data bits, no parity, 1 stop bit), LSB first.
- Buffers received bytes in a FIFO that the core reads over the bus.
- Raises a level interrupt intended for irq_fast_i / irq_external_i.

---
 rtl/uart_rx_dev.sv | 324 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_dev.sv
// rtl/uart_rx_dev.sv - memory-mapped UART receiver with RX FIFO and level interrupt
//
// Receives 8N1 characters (LSB first) on uart_rx_i, buffers them in a FIFO and
// exposes them on the device bus. Build option UART_RX_PARITY_EN switches the
// frame to 8E1 and enables the PERR flag.
//
// Ports:
//   clk_sys_i        system clock
//   rst_sys_ni       asynchronous active-low reset
//   device_req_i     single-cycle bus request, always granted
//   device_addr_i    byte address, bits [3:2] select the register
//   device_we_i      write enable
//   device_be_i      byte enables, bit 0 gates writes
//   device_wdata_i   write data
//   device_rvalid_o  response valid, one cycle after the request
//   device_rdata_o   read data (0 for writes)
//   uart_rx_i        asynchronous serial input, idle high
//   rx_irq_o         level interrupt
//
// Registers (offset = addr[3:2]*4):
//   0x0 DATA    [7:0] head byte, [31] EMPTY; a non-empty read pops
//   0x4 STATUS  [0] EMPTY [1] FULL [2] OVR [3] FERR [4] PERR [9:5] level
//   0x8 IRQ_EN  [0] RXNE_EN [1] ERR_EN
//   0xC         reads 0

module uart_rx_dev #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned FifoDepth      = 8
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_ni,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        uart_rx_i,
  output logic        rx_irq_o
);

  localparam int unsigned ClocksPerBit = ClockFrequency / BaudRate;
  localparam int unsigned CntW         = $clog2(ClocksPerBit);
  localparam logic [CntW-1:0] CntLast  = CntW'(ClocksPerBit - 1);
  localparam logic [CntW-1:0] CntHalf  = CntW'(ClocksPerBit / 2 - 1);
  localparam int unsigned PtrW         = $clog2(FifoDepth);
  localparam int unsigned LvlW         = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull  = LvlW'(FifoDepth);

  // ---------------------------------------------------------------------------
  // Input synchroniser; preset high so reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx_i};
    end
  end

  assign rx_s = sync_q[1];

  // ---------------------------------------------------------------------------
  // Receive FSM. Produces single-cycle registered events: push_q (with
  // push_data_q), ferr_set_q and, with parity, perr_set_q.
  // ---------------------------------------------------------------------------
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            push_q;
  logic [7:0]      push_data_q;
  logic            ferr_set_q;
`ifdef UART_RX_PARITY_EN
  logic            par_err_q;
  logic            perr_set_q;
`endif

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      ferr_set_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
      perr_set_q  <= 1'b0;
`endif
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_set_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end

        // Re-check the start bit half a bit later to reject glitches and to
        // align all following samples to mid-bit.
        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= StIdle;
            end else begin
              state_q <= StData;
              bit_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StData: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: data bits and parity bit together must XOR to 0.
        StParity: begin
          if (cnt_q == CntLast) begin
            cnt_q     <= '0;
            par_err_q <= ^{shift_q, rx_s};
            state_q   <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
`endif

        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= StIdle;
`ifdef UART_RX_PARITY_EN
              if (par_err_q) begin
                perr_set_q <= 1'b1;
              end else begin
                push_q      <= 1'b1;
                push_data_q <= shift_q;
              end
`else
              push_q      <= 1'b1;
              push_data_q <= shift_q;
`endif
            end else begin
              // Framing error wins over parity; only FERR is raised.
              ferr_set_q <= 1'b1;
              state_q    <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        // A line held low must not be re-framed as new characters.
        StBreak: begin
          if (rx_s) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO, flags and bus interface
  // ---------------------------------------------------------------------------
  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] count_q, count_d;
  logic            ovr_q, ovr_d;
  logic            ferr_q, ferr_d;
  logic [1:0]      irq_en_q, irq_en_d;
  logic            rvalid_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            irq_q, irq_d;

  logic            perr_cur, perr_nxt;
  logic [1:0]      reg_sel;
  logic            rd_req, wr_req, clr_stat;
  logic            fifo_empty, fifo_full;
  logic            pop, push_ok, ovr_set;
  logic [31:0]     rd_val;

  assign reg_sel    = device_addr_i[3:2];
  assign rd_req     = device_req_i & ~device_we_i;
  assign wr_req     = device_req_i & device_we_i & device_be_i[0];
  assign clr_stat   = wr_req & (reg_sel == 2'd1);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == LvlFull);
  assign pop        = rd_req & (reg_sel == 2'd0) & ~fifo_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = push_q & (~fifo_full | pop);
  assign ovr_set    = push_q & fifo_full & ~pop;

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  assign perr_d   = perr_set_q | (perr_q & ~(clr_stat & device_wdata_i[4]));
  assign perr_cur = perr_q;
  assign perr_nxt = perr_d;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end
`else
  assign perr_cur = 1'b0;
  assign perr_nxt = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + LvlW'(1);
      2'b01:   count_d = count_q - LvlW'(1);
      default: count_d = count_q;
    endcase

    // Set events take priority over a same-cycle W1C.
    ovr_d  = ovr_set    | (ovr_q  & ~(clr_stat & device_wdata_i[2]));
    ferr_d = ferr_set_q | (ferr_q & ~(clr_stat & device_wdata_i[3]));

    irq_en_d = irq_en_q;
    if (wr_req && reg_sel == 2'd2) begin
      irq_en_d = device_wdata_i[1:0];
    end

    rd_val = '0;
    case (reg_sel)
      2'd0:    rd_val = fifo_empty ? 32'h8000_0000 : {24'd0, mem_q[rd_ptr_q]};
      2'd1:    rd_val = {22'd0, 5'(count_q), perr_cur, ferr_q, ovr_q, fifo_full, fifo_empty};
      2'd2:    rd_val = {30'd0, irq_en_q};
      default: rd_val = '0;
    endcase
    rdata_d = rd_req ? rd_val : '0;

    // Built from next-state values so the registered IRQ tracks the flags
    // without an extra cycle of lag.
    irq_d = (irq_en_d[0] & (count_d != '0)) |
            (irq_en_d[1] & (ovr_d | ferr_d | perr_nxt));
  end

  always_ff @(posedge clk_sys_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      irq_en_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      irq_en_q <= irq_en_d;
      rvalid_q <= device_req_i;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign rx_irq_o        = irq_q;

  logic unused_bus;
  assign unused_bus = ^{device_addr_i[31:4], device_addr_i[1:0],
                        device_be_i[3:1], device_wdata_i[31:4]};

endmodule
